jacobi_sweep_ctrl: RTL and testbench

Sweep scheduler for the cyclic Jacobi eigen-solver. It walks every upper-triangle index pair (p,q) of an N×N symmetric matrix in cyclic-by-row order and reads the off-diagonal element a_pq for each pair. If |a_pq| exceeds a threshold, it sequences the angle unit and then the column-rotation datapath through start/done handshakes; otherwise it skips the pair. It repeats whole sweeps until one sweep needs no rotation (converged) or MAX_SWEEPS sweeps have run.

---
 rtl/jacobi_sweep_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_jacobi_sweep_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_sweep_ctrl.sv
// jacobi_sweep_ctrl
//   Sweep scheduler for a cyclic Jacobi eigen-solver. Walks the upper-triangle
//   pairs (p,q) of an N x N symmetric matrix in cyclic-by-row order, compares
//   |a_pq| against a threshold and, when above it, sequences the angle unit and
//   then the rotation datapath through start/done handshakes. Sweeps repeat
//   until one needs no rotation (converged) or MAX_SWEEPS sweeps have run.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a solve (accepted only when idle)
//   abort             synchronous abort back to idle, no done pulse
//   thresh            unsigned threshold, captured on accepted start
//   offdiag_val       signed a_pq for the current pair, sampled in EVAL
//   angle_done        angle unit finished (honoured only while waiting on it)
//   rot_done          rotation datapath finished (honoured only while waiting)
//   pair_p, pair_q    current pair, p < q
//   angle_start       one-cycle pulse in the first ANGLE cycle
//   rot_start         one-cycle pulse in the first ROT cycle
//   busy              high whenever not idle
//   done              one-cycle pulse when a solve ends
//   converged         result flag, valid with done, held until next start
//   sweep_cnt         number of completed sweeps
module jacobi_sweep_ctrl #(
    parameter int N          = 4,
    parameter int ACC_WIDTH  = 20,
    parameter int MAX_SWEEPS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [ACC_WIDTH-1:0]            thresh,
    input  logic signed [ACC_WIDTH-1:0]     offdiag_val,
    input  logic                            angle_done,
    input  logic                            rot_done,
    output logic [$clog2(N)-1:0]            pair_p,
    output logic [$clog2(N)-1:0]            pair_q,
    output logic                            angle_start,
    output logic                            rot_start,
    output logic                            busy,
    output logic                            done,
    output logic                            converged,
    output logic [$clog2(MAX_SWEEPS+1)-1:0] sweep_cnt
);

    localparam int PW = $clog2(N);
    localparam int SW = $clog2(MAX_SWEEPS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_ANGLE  = 3'd3;
    localparam logic [2:0] S_ROT    = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    localparam logic [PW-1:0]        Q_LAST  = PW'(N - 1);
    localparam logic [PW-1:0]        P_LAST  = PW'(N - 2);
    localparam logic [ACC_WIDTH-1:0] MAX_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};

    logic [2:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] thresh_q, thresh_d;
    logic [PW-1:0]        pair_p_q, pair_p_d;
    logic [PW-1:0]        pair_q_q, pair_q_d;
    logic [SW-1:0]        sweep_cnt_q, sweep_cnt_d;
    logic                 converged_q, converged_d;
    logic                 rot_flag_q, rot_flag_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 angle_start_q, angle_start_d;
    logic                 rot_start_q, rot_start_d;

    // Saturating magnitude: two's-complement negate, and the one value whose
    // negation overflows (most negative) is clamped to the largest positive.
    logic [ACC_WIDTH-1:0] neg_val;
    logic [ACC_WIDTH-1:0] abs_val;
    logic [SW-1:0]        sweep_inc;

    always_comb begin
        neg_val = ~$unsigned(offdiag_val) + ACC_WIDTH'(1);
        if (offdiag_val[ACC_WIDTH-1]) begin
            abs_val = neg_val[ACC_WIDTH-1] ? MAX_POS : neg_val;
        end else begin
            abs_val = $unsigned(offdiag_val);
        end
    end

    assign sweep_inc = sweep_cnt_q + SW'(1);

    always_comb begin
        state_d     = state_q;
        thresh_d    = thresh_q;
        pair_p_d    = pair_p_q;
        pair_q_d    = pair_q_q;
        sweep_cnt_d = sweep_cnt_q;
        converged_d = converged_q;
        rot_flag_d  = rot_flag_q;

        // Abort overrides every other transition and leaves results untouched.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_READ;
                        thresh_d    = thresh;
                        pair_p_d    = '0;
                        pair_q_d    = PW'(1);
                        sweep_cnt_d = '0;
                        converged_d = 1'b0;
                        rot_flag_d  = 1'b0;
                    end
                end
                S_READ: state_d = S_EVAL;
                S_EVAL: begin
                    if (abs_val > thresh_q) begin
                        state_d    = S_ANGLE;
                        rot_flag_d = 1'b1;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
                // A done seen alongside its own start pulse is stale; ignore it.
                S_ANGLE: if (angle_done && !angle_start_q) state_d = S_ROT;
                S_ROT:   if (rot_done && !rot_start_q) state_d = S_NEXT;
                S_NEXT: begin
                    if (pair_q_q < Q_LAST) begin
                        pair_q_d = pair_q_q + PW'(1);
                        state_d  = S_READ;
                    end else if (pair_p_q < P_LAST) begin
                        pair_p_d = pair_p_q + PW'(1);
                        pair_q_d = pair_p_q + PW'(2);
                        state_d  = S_READ;
                    end else begin
                        sweep_cnt_d = sweep_inc;
                        if (!rot_flag_q) begin
                            converged_d = 1'b1;
                            state_d     = S_FINISH;
                        end else if (sweep_inc == SW'(MAX_SWEEPS)) begin
                            converged_d = 1'b0;
                            state_d     = S_FINISH;
                        end else begin
                            pair_p_d   = '0;
                            pair_q_d   = PW'(1);
                            rot_flag_d = 1'b0;
                            state_d    = S_READ;
                        end
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end

        // Outputs are registered versions of next-state decodes, so the
        // pulses line up with the first cycle of the state they announce.
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_FINISH);
        angle_start_d = (state_q == S_EVAL)  && (state_d == S_ANGLE);
        rot_start_d   = (state_q == S_ANGLE) && (state_d == S_ROT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            thresh_q      <= '0;
            pair_p_q      <= '0;
            pair_q_q      <= PW'(1);
            sweep_cnt_q   <= '0;
            converged_q   <= 1'b0;
            rot_flag_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            angle_start_q <= 1'b0;
            rot_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            thresh_q      <= thresh_d;
            pair_p_q      <= pair_p_d;
            pair_q_q      <= pair_q_d;
            sweep_cnt_q   <= sweep_cnt_d;
            converged_q   <= converged_d;
            rot_flag_q    <= rot_flag_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            angle_start_q <= angle_start_d;
            rot_start_q   <= rot_start_d;
        end
    end

    // The internal pair resets to (0,1) but the visible pair reads 0 until the
    // first start, so idle outputs are all zero.
    assign pair_p      = busy_q ? pair_p_q : '0;
    assign pair_q      = busy_q ? pair_q_q : '0;
    assign angle_start = angle_start_q;
    assign rot_start   = rot_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = converged_q;
    assign sweep_cnt   = sweep_cnt_q;

endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
module tb_jacobi_sweep_ctrl;

    localparam int NN     = 4;
    localparam int AW     = 20;
    localparam int MAXS   = 3;
    localparam longint SATMAX = 524287;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [AW-1:0]        thresh = '0;
    logic signed [AW-1:0] offdiag_val = '0;
    logic                 angle_done = 1'b0;
    logic                 rot_done = 1'b0;
    logic [1:0]           pair_p, pair_q;
    logic                 angle_start, rot_start, busy, done, converged;
    logic [1:0]           sweep_cnt;

    jacobi_sweep_ctrl #(.N(NN), .ACC_WIDTH(AW), .MAX_SWEEPS(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .thresh(thresh), .offdiag_val(offdiag_val),
        .angle_done(angle_done), .rot_done(rot_done),
        .pair_p(pair_p), .pair_q(pair_q),
        .angle_start(angle_start), .rot_start(rot_start),
        .busy(busy), .done(done), .converged(converged), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [AW-1:0] mat [NN][NN];
    logic signed [AW-1:0] mm  [NN][NN];
    int exp_pairs[$], exp_rots[$], got_pairs[$], got_rots[$];
    bit m_conv;
    int m_sw, m_done;

    typedef struct {
        string                nm;
        logic signed [AW-1:0] base;
        int                   sp, sq;
        logic signed [AW-1:0] sv;
        logic [AW-1:0]        th;
        int                   da, dr;
        bit                   zero;
        bit                   e_conv;
        int                   e_sw, e_rots, e_done;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Whole-solve reference: enumerate pairs by row, apply the threshold rule
    // on saturated magnitudes and add up per-pair cycle costs.
    task automatic model(input logic [AW-1:0] th, input int da, input int dr, input bit zero);
        longint a;
        int     cyc;
        bit     any;
        exp_pairs.delete();
        exp_rots.delete();
        m_conv = 0; m_sw = 0; cyc = 0;
        for (int p = 0; p < NN; p++)
            for (int q = 0; q < NN; q++) mm[p][q] = mat[p][q];
        for (int s = 1; s <= MAXS; s++) begin
            any = 0;
            for (int p = 0; p < NN - 1; p++) begin
                for (int q = p + 1; q < NN; q++) begin
                    exp_pairs.push_back(p * 16 + q);
                    a = longint'(mm[p][q]);
                    if (a < 0) a = -a;
                    if (a > SATMAX) a = SATMAX;
                    if (a > longint'(th)) begin
                        any = 1;
                        exp_rots.push_back(p * 16 + q);
                        cyc += 5 + da + dr;
                        if (zero) mm[p][q] = '0;
                    end else begin
                        cyc += 3;
                    end
                end
            end
            m_sw = s;
            if (!any) begin
                m_conv = 1;
                break;
            end
        end
        m_done = cyc + 1;
    endtask

    task automatic fill(input logic signed [AW-1:0] base, input int sp, input int sq,
                        input logic signed [AW-1:0] sv);
        for (int p = 0; p < NN; p++)
            for (int q = 0; q < NN; q++) mat[p][q] = base;
        if (sp >= 0) mat[sp][sq] = sv;
    endtask

    task automatic tick();
        offdiag_val = mat[pair_p][pair_q];
        @(negedge clk);
    endtask

    task automatic run_case(input string nm, input logic [AW-1:0] th, input int da, input int dr,
                            input bit zero, input bit use_tbl, input bit e_conv,
                            input int e_sw, input int e_rots, input int e_done);
        int cyc, a_due, r_due, n_as, n_rs, done_cyc, bad_order, first_bad;
        bit fin, got_conv;
        int got_sw, pr;
        model(th, da, dr, zero);
        if (!use_tbl) begin
            e_conv = m_conv; e_sw = m_sw; e_rots = exp_rots.size(); e_done = m_done;
        end
        got_pairs.delete(); got_rots.delete();
        a_due = -1; r_due = -1; n_as = 0; n_rs = 0; done_cyc = -1;
        bad_order = 0; fin = 0; got_conv = 0; got_sw = -1;
        thresh = th;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        thresh = AW'($urandom);
        cyc = 1;
        while (cyc < 2000) begin
            if (busy) begin
                pr = int'(pair_p) * 16 + int'(pair_q);
                if (pair_p >= pair_q) bad_order++;
                if (got_pairs.size() == 0 || got_pairs[$] != pr) got_pairs.push_back(pr);
            end
            if (angle_start) begin
                n_as++;
                got_rots.push_back(int'(pair_p) * 16 + int'(pair_q));
                a_due = cyc + da;
            end
            if (rot_start) begin
                n_rs++;
                r_due = cyc + dr;
            end
            if (done) begin
                done_cyc = cyc; got_conv = converged; got_sw = int'(sweep_cnt); fin = 1;
                break;
            end
            offdiag_val = mat[pair_p][pair_q];
            angle_done = (cyc == a_due);
            rot_done   = (cyc == r_due);
            if (rot_done && zero) mat[pair_p][pair_q] = '0;
            @(negedge clk);
            cyc++;
        end
        angle_done = 1'b0;
        rot_done   = 1'b0;
        chk({nm, ".done_seen"}, fin, 1);
        if (fin) begin
            chk({nm, ".done_cycle"}, done_cyc, e_done);
            chk({nm, ".converged"}, got_conv, e_conv);
            chk({nm, ".sweep_cnt"}, got_sw, e_sw);
            chk({nm, ".angle_starts"}, n_as, e_rots);
            chk({nm, ".rot_starts"}, n_rs, e_rots);
            chk({nm, ".pair_order"}, bad_order, 0);
            chk({nm, ".pair_seq_len"}, got_pairs.size(), exp_pairs.size());
            first_bad = -1;
            for (int i = 0; i < got_pairs.size() && i < exp_pairs.size(); i++)
                if (first_bad < 0 && got_pairs[i] != exp_pairs[i]) first_bad = i;
            chk({nm, ".pair_seq_first_diff"}, first_bad, -1);
            first_bad = -1;
            chk({nm, ".rot_pair_len"}, got_rots.size(), exp_rots.size());
            for (int i = 0; i < got_rots.size() && i < exp_rots.size(); i++)
                if (first_bad < 0 && got_rots[i] != exp_rots[i]) first_bad = i;
            chk({nm, ".rot_pair_first_diff"}, first_bad, -1);
            @(negedge clk);
            chk({nm, ".busy_after"}, busy, 0);
            chk({nm, ".done_one_cycle"}, done, 0);
            chk({nm, ".conv_held"}, converged, e_conv);
        end else begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int n, seen_busy, seen_done, th_r, da_r, dr_r;
        logic [AW-1:0] th_v;

        tbl[0] = '{"converged",   20'sd3,     -1, 0, 20'sd0,   20'd5,       1, 1, 1'b0, 1'b1, 1, 0,  19};
        tbl[1] = '{"single_rot",  20'sd0,      0, 2, 20'sd100, 20'd5,       2, 3, 1'b1, 1'b1, 2, 1,  44};
        tbl[2] = '{"no_conv",     -20'sd50,   -1, 0, 20'sd0,   20'd10,      1, 1, 1'b0, 1'b0, 3, 18, 127};
        tbl[3] = '{"saturate",    20'sh80000, -1, 0, 20'sd0,   20'h7FFFF,   1, 1, 1'b0, 1'b1, 1, 0,  19};
        tbl[4] = '{"equal_skip",  20'sd5,     -1, 0, 20'sd0,   20'd5,       1, 1, 1'b0, 1'b1, 1, 0,  19};
        tbl[5] = '{"above_by_one", 20'sd6,    -1, 0, 20'sd0,   20'd5,       1, 1, 1'b1, 1'b1, 2, 6,  61};

        fill('0, -1, 0, '0);
        repeat (3) @(negedge clk);
        chk("reset_held_outputs", {pair_p, pair_q, angle_start, rot_start, busy, done, converged, sweep_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {pair_p, pair_q, angle_start, rot_start, busy, done, converged, sweep_cnt}, 0);
        seen_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) seen_busy++;
        end
        chk("idle_busy_stays_low", seen_busy, 0);

        foreach (tbl[i]) begin
            fill(tbl[i].base, tbl[i].sp, tbl[i].sq, tbl[i].sv);
            run_case(tbl[i].nm, tbl[i].th, tbl[i].da, tbl[i].dr, tbl[i].zero, 1'b1,
                     tbl[i].e_conv, tbl[i].e_sw, tbl[i].e_rots, tbl[i].e_done);
        end

        // Robustness: stale/spurious handshakes, start while busy, abort in ROT.
        fill('0, 0, 1, 20'sd100);
        thresh = 20'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!angle_start && n < 20) begin
            tick();
            n++;
        end
        chk("rb.angle_start_seen", angle_start, 1);
        chk("rb.angle_pair", int'(pair_p) * 16 + int'(pair_q), 1);
        angle_done = 1'b1; rot_done = 1'b1; start = 1'b1;
        tick();
        angle_done = 1'b0; rot_done = 1'b0; start = 1'b0;
        chk("rb.stale_angle_done_ignored", rot_start, 0);
        chk("rb.still_busy", busy, 1);
        angle_done = 1'b1;
        tick();
        angle_done = 1'b0;
        chk("rb.rot_start_after_angle_done", rot_start, 1);
        abort = 1'b1; rot_done = 1'b1;
        tick();
        abort = 1'b0; rot_done = 1'b0;
        chk("rb.abort_idle", busy, 0);
        seen_done = done;
        repeat (5) begin
            tick();
            if (done || busy) seen_done++;
        end
        chk("rb.no_done_after_abort", seen_done, 0);
        fill(20'sd3, -1, 0, '0);
        run_case("after_abort", 20'd5, 1, 1, 1'b0, 1'b1, 1'b1, 1, 0, 19);

        // Randomized solves checked against the reference model.
        for (int r = 0; r < 8; r++) begin
            th_r = int'($urandom_range(0, 120));
            th_v = AW'(th_r);
            for (int p = 0; p < NN; p++)
                for (int q = 0; q < NN; q++) begin
                    if ($urandom_range(0, 9) == 0) mat[p][q] = 20'sh80000;
                    else mat[p][q] = AW'(int'($urandom_range(0, 300)) - 150);
                end
            da_r = int'($urandom_range(1, 3));
            dr_r = int'($urandom_range(1, 3));
            run_case($sformatf("rand%0d", r), th_v, da_r, dr_r, ($urandom_range(0, 3) != 0),
                     1'b0, 1'b0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
